// File: rtl/board_store.sv
// rtl/board_store.sv - board array to Board_Ram bulk/tile writer
// One write port shared by a full-board sweep (S_STORE) and single-tile updates (S_IDLE).
module board_store #(
  parameter int ROWS    = 36,
  parameter int COLS    = 28,
  parameter int N_TILES = ROWS * COLS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_store,
  input  logic [7:0] i_board [0:ROWS-1][0:COLS-1],
  input  logic       i_tile_valid,
  input  logic [5:0] i_tile_row,
  input  logic [4:0] i_tile_col,
  input  logic [7:0] i_tile_data,
  output logic       o_tile_ready,
  output logic [9:0] o_ram_addr,
  output logic [7:0] o_ram_data,
  output logic       o_ram_wren,
  output logic       o_busy,
  output logic       o_store_done,
  output logic       o_tile_err
);

  typedef enum logic {S_IDLE, S_STORE} state_t;

  localparam logic [9:0] LAST_ADDR = 10'(N_TILES - 1);
  localparam logic [9:0] COLS_W    = 10'(COLS);
  localparam logic [4:0] LAST_COL  = 5'(COLS - 1);

  state_t     state_q, state_d;
  logic [5:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic       last_q, last_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       wren_q, wren_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [9:0] cur_addr;
  logic [9:0] tile_addr;
  logic       tile_in_range;

  assign cur_addr      = {4'b0, row_q} * COLS_W + {5'b0, col_q};
  assign tile_addr     = {4'b0, i_tile_row} * COLS_W + {5'b0, i_tile_col};
  assign tile_in_range = (i_tile_row < 6'(ROWS)) && (i_tile_col < 5'(COLS));

  // A pending store always wins the port, so the tile source must wait.
  assign o_tile_ready = (state_q == S_IDLE) && !i_store;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_store) begin
          state_d = S_STORE;
          row_d   = 6'd0;
          col_d   = 5'd0;
          last_d  = 1'b0;
        end else if (i_tile_valid) begin
          if (tile_in_range) begin
            addr_d = tile_addr;
            data_d = i_tile_data;
            wren_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STORE: begin
        // One drain cycle after the final write keeps busy high until done.
        if (last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          last_d  = 1'b0;
        end else begin
          addr_d = cur_addr;
          data_d = i_board[row_q][col_q];
          wren_d = 1'b1;
          if (cur_addr == LAST_ADDR) begin
            last_d = 1'b1;
          end else if (col_q == LAST_COL) begin
            col_d = 5'd0;
            row_d = row_q + 6'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      row_q   <= 6'd0;
      col_q   <= 5'd0;
      last_q  <= 1'b0;
      addr_q  <= 10'd0;
      data_q  <= 8'd0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_ram_addr   = addr_q;
  assign o_ram_data   = data_q;
  assign o_ram_wren   = wren_q;
  assign o_busy       = (state_q == S_STORE);
  assign o_store_done = done_q;
  assign o_tile_err   = err_q;

endmodule

// File: tb/tb_board_store.sv
// tb/tb_board_store.sv - randomized self-checking bench for board_store
// Writes, error pulses and busy/done are logged per cycle and compared with a tile-list model.
module tb_board_store;
  localparam int ROWS = 36;
  localparam int COLS = 28;
  localparam int N    = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst;
  logic       store;
  logic [7:0] board [0:ROWS-1][0:COLS-1];
  logic       tv;
  logic [5:0] tr;
  logic [4:0] tc;
  logic [7:0] td;
  logic       ready;
  logic [9:0] addr;
  logic [7:0] data;
  logic       wren, busy, done, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wa[$], wd[$], wc[$], ec[$];
  int donecnt, done_cyc, busy_n, busy_first, busy_last;
  logic [1:0] done_flags;

  board_store #(.ROWS(ROWS), .COLS(COLS), .N_TILES(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_store(store), .i_board(board),
    .i_tile_valid(tv), .i_tile_row(tr), .i_tile_col(tc), .i_tile_data(td),
    .o_tile_ready(ready), .o_ram_addr(addr), .o_ram_data(data), .o_ram_wren(wren),
    .o_busy(busy), .o_store_done(done), .o_tile_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wren) begin
      wa.push_back(int'(addr));
      wd.push_back(int'(data));
      wc.push_back(cyc);
    end
    if (err) ec.push_back(cyc);
    if (done) begin
      donecnt++;
      done_cyc   = cyc;
      done_flags = {wren, busy};
    end
    if (busy) begin
      if (busy_n == 0) busy_first = cyc;
      busy_last = cyc;
      busy_n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); ec.delete();
    donecnt = 0; busy_n = 0; done_cyc = -1; done_flags = 2'b11;
  endtask

  task automatic test_reset();
    rst = 1'b1; store = 1'b0; tv = 1'b0; tr = '0; tc = '0; td = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) board[r][c] = 8'h00;
    repeat (3) step();
    total++; if (addr !== 10'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr); end
    total++; if (data !== 8'd0)  begin bad++; $display("FAIL reset_data got=%0d exp=0", data); end
    total++; if (wren !== 1'b0)  begin bad++; $display("FAIL reset_wren got=%b exp=0", wren); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    step();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", ready); end
  endtask

  // mode 0: counting pattern, 1: random board, 2: random board with i_store held high
  task automatic test_store(input int mode);
    int k, nbad, first_bad, lim;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = (mode == 0) ? 8'((r * COLS + c) & 255) : 8'($urandom);
    clear_log();
    store = 1'b1;
    step();
    k = cyc;
    if (mode != 2) store = 1'b0;
    for (int b = 0; b < 1200 && donecnt == 0; b++) step();
    total++; if (donecnt == 0) begin bad++; $display("FAIL store%0d_timeout got=no_done exp=done", mode); end
    total++; if (wa.size() != N) begin bad++; $display("FAIL store%0d_count got=%0d exp=%0d", mode, wa.size(), N); end
    nbad = 0; first_bad = -1;
    lim = (wa.size() < N) ? wa.size() : N;
    for (int n = 0; n < lim; n++)
      if (wa[n] != n || wd[n] != int'(board[n / COLS][n % COLS]) || wc[n] != k + 1 + n) begin
        if (nbad == 0) first_bad = n;
        nbad++;
      end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL store%0d_writes got=%0d_bad_first_at_%0d exp=0_bad", mode, nbad, first_bad);
    end
    total++; if (donecnt != 1 || done_cyc != k + N + 1) begin
      bad++; $display("FAIL store%0d_done got=cnt%0d@%0d exp=cnt1@%0d", mode, donecnt, done_cyc, k + N + 1);
    end
    total++; if (done_flags !== 2'b00) begin bad++; $display("FAIL store%0d_done_flags got=%b exp=00", mode, done_flags); end
    total++; if (busy_n != N + 1 || busy_first != k || busy_last != k + N) begin
      bad++; $display("FAIL store%0d_busy got=%0d[%0d..%0d] exp=%0d[%0d..%0d]",
                      mode, busy_n, busy_first, busy_last, N + 1, k, k + N);
    end
    total++; if (busy !== (mode == 2)) begin bad++; $display("FAIL store%0d_restart got=%b exp=%b", mode, busy, mode == 2); end
    store = 1'b0;
    if (mode == 2) begin
      rst = 1'b1; step(); rst = 1'b0; step();
    end
  endtask

  task automatic test_tile();
    int ea[$], ed[$], es[$], ee[$];
    int r, c, t, nbad;
    clear_log();
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin r = 35; c = 27; td = 8'h5A; end
      else if (i == 1) begin r = 36; c = 0; td = 8'h11; end
      else if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 63); c = $urandom_range(0, 31); td = 8'($urandom);
      end else begin
        r = $urandom_range(0, ROWS - 1); c = $urandom_range(0, COLS - 1); td = 8'($urandom);
      end
      tv = 1'b1; tr = 6'(r); tc = 5'(c);
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL tile_ready[%0d] got=%b exp=1", i, ready); end
      step();
      t = cyc;
      if (r < ROWS && c < COLS) begin
        ea.push_back(r * COLS + c); ed.push_back(int'(td)); es.push_back(t);
      end else begin
        ee.push_back(t);
      end
    end
    tv = 1'b0;
    step(); step();
    total++; if (wa.size() != ea.size()) begin bad++; $display("FAIL tile_count got=%0d exp=%0d", wa.size(), ea.size()); end
    nbad = 0;
    for (int n = 0; n < ea.size() && n < wa.size(); n++)
      if (wa[n] != ea[n] || wd[n] != ed[n] || wc[n] != es[n]) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL tile_writes got=%0d_bad exp=0_bad", nbad); end
    nbad = (ec.size() == ee.size()) ? 0 : 1;
    for (int n = 0; n < ee.size() && n < ec.size(); n++) if (ec[n] != ee[n]) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL tile_err got=%0d_pulses exp=%0d_pulses", ec.size(), ee.size()); end
  endtask

  task automatic test_collision();
    int k, t, b;
    logic done_at_ready;
    clear_log();
    store = 1'b1; tv = 1'b1; tr = 6'd5; tc = 5'd5; td = 8'hC3;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL coll_ready got=%b exp=0", ready); end
    step();
    store = 1'b0;
    k = cyc;
    for (b = 0; b < 1200; b++) begin
      if (ready) break;
      step();
    end
    done_at_ready = done;
    total++; if (done_at_ready !== 1'b1 || cyc != k + N + 1) begin
      bad++; $display("FAIL coll_accept got=done%b@%0d exp=done1@%0d", done_at_ready, cyc, k + N + 1);
    end
    step();
    t = cyc;
    tv = 1'b0;
    step(); step();
    total++; if (wa.size() != N + 1 || donecnt != 1) begin
      bad++; $display("FAIL coll_count got=%0d/%0d exp=%0d/1", wa.size(), donecnt, N + 1);
    end else if (wa[N] != 5 * COLS + 5 || wd[N] != 'hC3 || wc[N] != t) begin
      bad++; $display("FAIL coll_tile got=%0d/%0h@%0d exp=%0d/c3@%0d", wa[N], wd[N], wc[N], 5 * COLS + 5, t);
    end
  endtask

  task automatic test_reset_mid();
    int n_at;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) board[r][c] = 8'($urandom);
    clear_log();
    store = 1'b1; step(); store = 1'b0;
    for (int b = 0; b < 1200 && wa.size() < 500; b++) step();
    #2;
    rst = 1'b1;
    #1;
    total++; if ({addr, data, wren, busy, done, err} !== 22'd0) begin
      bad++; $display("FAIL midrst_outputs got=%0h exp=0", {addr, data, wren, busy, done, err});
    end
    n_at = wa.size();
    step();
    rst = 1'b0;
    repeat (20) step();
    total++; if (donecnt != 0 || wa.size() != n_at || n_at != 500) begin
      bad++; $display("FAIL midrst_abandon got=done%0d/writes%0d exp=done0/writes500", donecnt, wa.size());
    end
  endtask

  initial begin
    test_reset();
    test_store(0);
    test_tile();
    test_collision();
    test_reset_mid();
    test_store(1);
    test_store(2);
    test_tile();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_store.md
BOARD_STORE -- requirements
Module: board_store

Interface
REQ-001 SHALL have parameter ROWS, default 36, board row count.
REQ-002 SHALL have parameter COLS, default 28, board column count.
REQ-003 SHALL have parameter N_TILES, default 1008 (ROWS*COLS), number of RAM words written per bulk store.
REQ-004 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_store  input  1  bulk-store request, sampled only in S_IDLE.
REQ-007 SHALL have port i_board  input  [7:0][0:35][0:27]  live board array to store, row-major.
REQ-008 SHALL have port i_tile_valid  input  1  single-tile write request valid.
REQ-009 SHALL have port i_tile_row  input  6  tile row index.
REQ-010 SHALL have port i_tile_col  input  5  tile column index.
REQ-011 SHALL have port i_tile_data  input  8  tile value to write.
REQ-012 SHALL have port o_tile_ready  output  1  tile request accepted this cycle when high together with i_tile_valid.
REQ-013 SHALL have port o_ram_addr  output  10  Board_Ram address, registered.
REQ-014 SHALL have port o_ram_data  output  8  Board_Ram write data, registered.
REQ-015 SHALL have port o_ram_wren  output  1  Board_Ram write enable, registered; RAM samples it on falling i_clk.
REQ-016 SHALL have port o_busy  output  1  high while in S_STORE.
REQ-017 SHALL have port o_store_done  output  1  one-cycle pulse after the last bulk write.
REQ-018 SHALL have port o_tile_err  output  1  one-cycle pulse for a dropped out-of-range tile request.

Function
REQ-019 SHALL implement states S_IDLE and S_STORE; S_IDLE -> S_STORE on i_store=1; S_STORE -> S_IDLE after issuing index N_TILES-1.
REQ-020 SHALL, in S_STORE, hold row/col counters (no divider) starting at (0,0), advancing col each cycle, wrapping col 27 -> 0 with row+1.
REQ-021 SHALL, for each S_STORE cycle with counters (r,c), register o_ram_addr=r*28+c, o_ram_data=i_board[r][c], o_ram_wren=1 at the next edge.
REQ-022 SHALL, with i_store sampled at edge k, present writes for addresses 0..1007 in cycles k+2..k+1009, one per cycle, no gaps.
REQ-023 SHALL assert o_store_done for exactly cycle k+1010, with o_ram_wren=0 and o_busy=0 in that cycle.
REQ-024 SHALL drive o_busy=1 in cycles k+1..k+1009; caller holds i_board stable while o_busy=1.
REQ-025 SHALL drive o_tile_ready = (state==S_IDLE) & ~i_store (combinational).
REQ-026 SHALL, on a tile handshake at edge t with row<36 and col<28, present exactly one write (addr=row*28+col, data=i_tile_data, wren=1) in cycle t+1.
REQ-027 SHALL, on a tile handshake with row>=36 or col>=28, issue no write and pulse o_tile_err in cycle t+1.
REQ-028 SHALL accept back-to-back tile handshakes, one per cycle, each producing its write in the following cycle.
REQ-029 SHALL give i_store priority over i_tile_valid in the same S_IDLE cycle; the tile request is not accepted and stays pending at the source.
REQ-030 SHALL ignore i_store while in S_STORE; no restart, no second done pulse.
REQ-031 SHALL deassert o_ram_wren in every cycle with no write scheduled.
REQ-032 SHALL compute address arithmetic at 10 bits; max address 1007, no overflow.

Reset
REQ-033 SHALL, while i_rst=1, force S_IDLE, counters 0, o_ram_addr=0, o_ram_data=0, o_ram_wren=0, o_busy=0, o_store_done=0, o_tile_err=0.
REQ-034 SHALL, on reset mid-store, abandon the store without an o_store_done pulse; the first post-reset i_store restarts at address 0.

Verification
REQ-035 SHALL cover bulk store: i_board[r][c]=(r*28+c)&8'hFF, i_store pulse -> 1008 consecutive writes, addr n data n&FF, then single o_store_done.
REQ-036 SHALL cover tile write: valid, row=35, col=27, data=8'h5A in S_IDLE -> ready=1, next cycle addr=1007 data=5A wren=1 for one cycle.
REQ-037 SHALL cover out-of-range tile: row=36, col=0 -> no wren, o_tile_err pulse one cycle.
REQ-038 SHALL cover collision: i_store and i_tile_valid same cycle -> ready=0, store runs; tile accepted only after o_store_done.
REQ-039 SHALL cover reset mid-store: i_rst=1 at write 500 -> all outputs 0 immediately, no done pulse; new i_store writes from address 0.
REQ-040 SHALL cover store re-request: i_store held high through S_STORE -> exactly 1008 writes and one o_store_done, then a new store on the following sample.
